systolic_result_drain: RTL and testbench

- Output-side companion of the 3x3 systolic matrix multiplier.
- Captures the 9 accumulated results of C = A x B, which arrive skewed column-by-column from the array's bottom edge, and de-skews them into an aligned 3x3 buffer.
- Computes the element sum and its 4-bit leading-one normalized value, then presents the aligned matrix through a valid/ready handshake to downstream logic.

---
 rtl/systolic_result_drain_if.sv | 24 ++
 rtl/systolic_result_drain.sv | 135 +++++++++++++
 tb/tb_systolic_result_drain.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/systolic_result_drain_if.sv
// Column-beat input and aligned-frame output bundle of the systolic result drain.
// master = array/consumer side, slave = the drain itself.
interface systolic_result_drain_if #(
    parameter int W = 14
);
    logic [2:0]       col_valid;
    logic [3*W-1:0]   col_data;
    logic             out_valid;
    logic             out_ready;
    logic [9*W-1:0]   out_c;
    logic [W+3:0]     out_sum;
    logic [3:0]       out_norm;
    logic             overflow;

    modport master (
        output col_valid, col_data, out_ready,
        input  out_valid, out_c, out_sum, out_norm, overflow
    );

    modport slave (
        input  col_valid, col_data, out_ready,
        output out_valid, out_c, out_sum, out_norm, overflow
    );
endinterface

// File: rtl/systolic_result_drain.sv
// De-skews the 3x3 systolic array's column results into an aligned frame,
// then presents the frame, its element sum and the normalized sum via valid/ready.

// One column's row counter and storage; each column fills independently of the others.
module srd_column #(
    parameter int W    = 14,
    parameter int ROWS = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     beat,
    input  logic                     open,
    input  logic                     restart,
    input  logic [W-1:0]             data,
    output logic [ROWS-1:0][W-1:0]   rows,
    output logic                     fill_done,
    output logic                     drop
);
    localparam int RW = $clog2(ROWS + 1);

    logic [RW-1:0] rcnt;
    logic          full;
    logic          take;

    assign full      = (rcnt == RW'(ROWS));
    assign take      = open && beat && !full;
    assign fill_done = full || (take && rcnt == RW'(ROWS - 1));
    assign drop      = beat && !restart && !take;

    // restart: handshake in DONE; a beat in that same cycle becomes row 0 of the next frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt <= '0;
            rows <= '0;
        end else if (restart) begin
            rcnt <= beat ? RW'(1) : '0;
            if (beat) rows[0] <= data;
        end else if (take) begin
            for (int r = 0; r < ROWS; r++)
                if (rcnt == RW'(r)) rows[r] <= data;
            rcnt <= rcnt + RW'(1);
        end
    end
endmodule

module systolic_result_drain #(
    parameter int W = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    systolic_result_drain_if.slave  bus
);
    localparam int N = 3;

    typedef enum logic [1:0] {IDLE, FILL, SUM, DONE} state_t;

    state_t                state, state_nxt;
    logic                  hs;
    logic                  open;
    logic [N-1:0]          fill_done;
    logic [N-1:0]          drop;
    logic [N-1:0][W-1:0]   col_rows [N];
    logic [W+3:0]          sum_c;
    logic [W+3:0]          sum_q;
    logic [3:0]            norm_q;
    logic                  ovf_q;

    assign hs   = (state == DONE) && bus.out_ready;
    assign open = (state == IDLE) || (state == FILL);

    for (genvar j = 0; j < N; j++) begin : g_col
        srd_column #(.W(W), .ROWS(N)) u_col (
            .clk       (clk),
            .rst_n     (rst_n),
            .beat      (bus.col_valid[j]),
            .open      (open),
            .restart   (hs),
            .data      (bus.col_data[j*W +: W]),
            .rows      (col_rows[j]),
            .fill_done (fill_done[j]),
            .drop      (drop[j])
        );
        for (genvar i = 0; i < N; i++) begin : g_row
            assign bus.out_c[(N*i+j)*W +: W] = col_rows[j][i];
        end
    end

    // 4-bit window from the leading one; small sums fall back to the low nibble
    function automatic logic [3:0] lead_norm(input logic [W+3:0] s);
        logic [3:0] n;
        n = s[3:0];
        for (int i = 3; i < W + 4; i++)
            if (s[i]) n = s[i -: 4];
        return n;
    endfunction

    always_comb begin
        sum_c = '0;
        for (int j = 0; j < N; j++)
            for (int i = 0; i < N; i++)
                sum_c = sum_c + (W+4)'(col_rows[j][i]);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (|bus.col_valid) state_nxt = FILL;
            FILL: if (&fill_done)     state_nxt = SUM;
            SUM:                      state_nxt = DONE;
            DONE: if (hs)             state_nxt = (|bus.col_valid) ? FILL : IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sum_q  <= '0;
            norm_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            ovf_q <= ovf_q | (|drop);
            if (state == SUM) begin
                sum_q  <= sum_c;
                norm_q <= lead_norm(sum_c);
            end
        end
    end

    assign bus.out_valid = (state == DONE);
    assign bus.out_sum   = sum_q;
    assign bus.out_norm  = norm_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: skewed frames, backpressure, drops,
// extreme values, back-to-back handshake capture and async reset mid-fill.
module tb_systolic_result_drain;
    localparam int W = 14;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    systolic_result_drain_if #(.W(W)) bus ();
    systolic_result_drain #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int nchk = 0;
    int nerr = 0;

    logic [W-1:0] m1  [9] = '{14'd1, 14'd2, 14'd3, 14'd4, 14'd5, 14'd6, 14'd7, 14'd8, 14'd9};
    logic [W-1:0] m5  [9] = '{14'd10, 14'd20, 14'd30, 14'd40, 14'd50, 14'd60, 14'd70, 14'd80, 14'd90};
    logic [W-1:0] m3a [9] = '{14'd5, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0};
    logic [W-1:0] m0  [9] = '{default: 14'd0};
    logic [W-1:0] mx  [9] = '{default: 14'h3FFF};

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9*W-1:0] pack(input logic [W-1:0] m [9]);
        logic [9*W-1:0] v;
        for (int k = 0; k < 9; k++) v[k*W +: W] = m[k];
        return v;
    endfunction

    // Nominal feeder skew: column j delivers rows 0..2 in cycles j..j+2.
    task automatic send_frame(input logic [W-1:0] m [9]);
        for (int t = 0; t < 5; t++) begin
            bus.col_valid = '0;
            bus.col_data  = '0;
            for (int j = 0; j < 3; j++)
                if (t >= j && t - j < 3) begin
                    bus.col_valid[j]       = 1'b1;
                    bus.col_data[j*W +: W] = m[(t-j)*3 + j];
                end
            tick();
        end
        bus.col_valid = '0;
        bus.col_data  = '0;
    endtask

    // Called right after the 9th beat's capture edge.
    task automatic check_frame(input string tag, input logic [W-1:0] m [9],
                               input int unsigned esum, input int unsigned enorm, input logic eov);
        check({tag, "_lat"}, 128'(bus.out_valid), 128'(0));
        tick();
        check({tag, "_valid"}, 128'(bus.out_valid), 128'(1));
        check({tag, "_c"},     128'(bus.out_c),     128'(pack(m)));
        check({tag, "_sum"},   128'(bus.out_sum),   128'(esum));
        check({tag, "_norm"},  128'(bus.out_norm),  128'(enorm));
        check({tag, "_ovf"},   128'(bus.overflow),  128'(eov));
    endtask

    initial begin
        bus.col_valid = '0;
        bus.col_data  = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("rst_valid", 128'(bus.out_valid), 128'(0));
        check("rst_c",     128'(bus.out_c),     128'(0));
        check("rst_sum",   128'(bus.out_sum),   128'(0));
        check("rst_norm",  128'(bus.out_norm),  128'(0));
        check("rst_ovf",   128'(bus.overflow),  128'(0));
        rst_n = 1'b1;

        // 1: skewed frame, immediate acceptance
        send_frame(m1);
        check_frame("t1", m1, 45, 11, 1'b0);
        tick();
        check("t1_hs", 128'(bus.out_valid), 128'(0));

        // 3: small and zero sums
        send_frame(m3a);
        check_frame("t3a", m3a, 5, 5, 1'b0);
        tick();
        send_frame(m0);
        check_frame("t3b", m0, 0, 0, 1'b0);
        tick();

        // 4: all-max elements
        send_frame(mx);
        check_frame("t4", mx, 147447, 8, 1'b0);
        tick();

        // 5: next frame's first beat lands on the handshake cycle
        bus.out_ready = 1'b0;
        send_frame(m1);
        check_frame("t5a", m1, 45, 11, 1'b0);
        bus.out_ready = 1'b1;
        send_frame(m5);
        check_frame("t5b", m5, 450, 14, 1'b0);
        tick();
        check("t5_hs", 128'(bus.out_valid), 128'(0));

        // 2: backpressure with a stray beat
        bus.out_ready = 1'b0;
        send_frame(m1);
        check_frame("t2", m1, 45, 11, 1'b0);
        bus.col_valid    = 3'b001;
        bus.col_data     = '0;
        bus.col_data[W-1:0] = 14'd99;
        tick();
        bus.col_valid = '0;
        bus.col_data  = '0;
        for (int k = 0; k < 4; k++) tick();
        check("t2_hold_valid", 128'(bus.out_valid), 128'(1));
        check("t2_hold_c",     128'(bus.out_c),     128'(pack(m1)));
        check("t2_hold_sum",   128'(bus.out_sum),   128'(45));
        check("t2_hold_norm",  128'(bus.out_norm),  128'(11));
        check("t2_ovf",        128'(bus.overflow),  128'(1));
        bus.out_ready = 1'b1;
        tick();
        check("t2_hs", 128'(bus.out_valid), 128'(0));

        // 6: async reset after 4 beats of a partial frame
        bus.col_valid = 3'b011;
        bus.col_data  = {14'd0, 14'd2, 14'd1};
        tick();
        bus.col_data  = {14'd0, 14'd5, 14'd4};
        tick();
        bus.col_valid = '0;
        bus.col_data  = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 128'(bus.out_valid), 128'(0));
        check("t6_rst_sum",   128'(bus.out_sum),   128'(0));
        check("t6_rst_norm",  128'(bus.out_norm),  128'(0));
        check("t6_rst_ovf",   128'(bus.overflow),  128'(0));
        #1;
        rst_n = 1'b1;
        send_frame(m1);
        check_frame("t6", m1, 45, 11, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
